// File: rtl/rv_data_mem.sv
// Word-addressed data RAM for the MEM stage: synchronous write, combinational read,
// whole array cleared by async reset. Define DMEM_ERR_EN to add the err access-fault output.
module rv_data_mem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  // Upper address bits are compared rather than dropped, so nothing aliases into the array.
  function automatic logic addr_in_range(input logic [31:0] a);
    return (a < LIMIT);
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] idx_s;
  logic          in_range_s;

  assign idx_s      = addr[AW+1:2];
  assign in_range_s = addr_in_range(addr);

  // Storage array: cleared asynchronously, written on the rising edge when enabled and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (mem_write && in_range_s) begin
      mem_r[idx_s] <= write_data;
    end else begin
      mem_r[idx_s] <= mem_r[idx_s];
    end
  end

  // Zero-latency load path, gated by reset, mem_read and the range check.
  always_comb begin
    read_data = 32'h0000_0000;
    if (!rst_n) begin
      read_data = 32'h0000_0000;
    end else if (mem_read && in_range_s) begin
      read_data = mem_r[idx_s];
    end else begin
      read_data = 32'h0000_0000;
    end
  end

`ifdef DMEM_ERR_EN
  // Access fault flag: misaligned or out-of-range access while an access is requested.
  always_comb begin
    err = 1'b0;
    if (!rst_n) begin
      err = 1'b0;
    end else if ((mem_read || mem_write) && ((addr[1:0] != 2'b00) || !in_range_s)) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rv_data_mem.sv
// Directed self-checking bench for rv_data_mem; err checks are included when DMEM_ERR_EN is defined.
module tb_rv_data_mem;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  rv_data_mem #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
`ifdef DMEM_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    addr      = a;
    #1;
    check32(tag, read_data, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'h0000_0000;
    write_data = 32'h0000_0000;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    do_read("rst_0x000", 32'h0000_0000, 32'h0000_0000);
    do_read("rst_0x004", 32'h0000_0004, 32'h0000_0000);
    do_read("rst_0x3fc", 32'h0000_03FC, 32'h0000_0000);

    do_write(32'h0000_0000, 32'hDEAD_BEEF);
    do_write(32'h0000_0004, 32'hCAFE_BABE);
    do_write(32'h0000_0010, 32'hFEED_FACE);
    do_read("rd_0x000", 32'h0000_0000, 32'hDEAD_BEEF);
    do_read("rd_0x004", 32'h0000_0004, 32'hCAFE_BABE);
    do_read("rd_0x010", 32'h0000_0010, 32'hFEED_FACE);
    do_read("rd_0x005_low_bits_ignored", 32'h0000_0005, 32'hCAFE_BABE);

    do_read("unwritten_0x01c", 32'h0000_001C, 32'h0000_0000);
    mem_read = 1'b0;
    addr     = 32'h0000_0000;
    #1;
    check32("gated_read_0x000", read_data, 32'h0000_0000);

    // Store attempt with mem_write held low across an edge.
    @(negedge clk);
    mem_write  = 1'b0;
    addr       = 32'h0000_0008;
    write_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    do_read("no_we_0x008", 32'h0000_0008, 32'h0000_0000);

    do_write(32'h0000_0400, 32'hAAAA_AAAA);
    do_read("oor_rd_0x400", 32'h0000_0400, 32'h0000_0000);
    do_read("no_alias_0x000", 32'h0000_0000, 32'hDEAD_BEEF);

    do_write(32'h0000_03FC, 32'h0BAD_F00D);
    do_read("top_word_0x3fc", 32'h0000_03FC, 32'h0BAD_F00D);

    // Read and write in the same cycle: old data before the edge, new data after.
    @(negedge clk);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    addr       = 32'h0000_0000;
    write_data = 32'h1111_1111;
    #1;
    check32("rw_before_edge", read_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check32("rw_after_edge", read_data, 32'h1111_1111);
    mem_write = 1'b0;

`ifdef DMEM_ERR_EN
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h0000_0002;
    #1;
    check1("err_misaligned_0x002", err, 1'b1);
    addr = 32'h0000_0404;
    #1;
    check1("err_oor_0x404", err, 1'b1);
    addr = 32'h0000_0004;
    #1;
    check1("err_ok_0x004", err, 1'b0);
    mem_read = 1'b0;
    addr     = 32'h0000_0002;
    #1;
    check1("err_idle_0x002", err, 1'b0);
`endif

    // Async reset lands mid-write: clear wins and the pending store is lost.
    @(negedge clk);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    addr       = 32'h0000_0004;
    write_data = 32'h9999_9999;
    #1;
    check32("pre_async_rst_0x004", read_data, 32'hCAFE_BABE);
    #1;
    rst_n = 1'b0;
    #1;
    check32("async_rst_0x004", read_data, 32'h0000_0000);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_read("post_rst_0x004", 32'h0000_0004, 32'h0000_0000);
    do_read("post_rst_0x010", 32'h0000_0010, 32'h0000_0000);
    do_read("post_rst_0x3fc", 32'h0000_03FC, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
